uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx_if.sv | 9 +
 rtl/uart_frame_tx.sv | 113 +++++++++++
 tb/tb_uart_frame_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_if.sv
// Host-side load handshake for uart_frame_tx: byte, request and holding-register-empty flag.
interface uart_frame_tx_if;
  logic [7:0] Data;
  logic       Data_Valid;
  logic       Ready;

  modport master (output Data, output Data_Valid, input Ready);
  modport slave  (input Data, input Data_Valid, output Ready);
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start, 8 data bits LSB first, parity, STOP_BITS stop bits.
// One-byte holding register lets the host load the next byte while a frame is on the line.
module uart_frame_tx #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CLK_Baud,
  uart_frame_tx_if.slave   host,
  output logic             Serial_output,
  output logic             Busy,
  output logic             Tx_Done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q;
  logic        baud_q;
  logic [7:0]  hold_q;
  logic        full_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [2:0]  idx_q;
  logic [1:0]  stop_q;
  logic        line_q;
  logic        busy_q;
  logic        done_q;

  logic tick, stop_last, start_now;

  assign tick      = CLK_Baud & ~baud_q;
  assign stop_last = (stop_q == 2'(STOP_BITS - 1));
  // A new frame starts from IDLE or straight off the last stop bit, so frames abut with no idle bit.
  assign start_now = tick & full_q &
                     ((state_q == IDLE) | ((state_q == STOP) & stop_last));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      baud_q  <= 1'b0;
      hold_q  <= 8'h00;
      full_q  <= 1'b0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      idx_q   <= 3'd0;
      stop_q  <= 2'd0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      baud_q <= CLK_Baud;
      done_q <= tick & (state_q == STOP) & stop_last;

      if (host.Data_Valid && !full_q) begin
        hold_q <= host.Data;
        full_q <= 1'b1;
      end

      if (start_now) begin
        state_q <= START;
        shift_q <= hold_q;
        par_q   <= (^hold_q) ^ PARITY_ODD;
        full_q  <= 1'b0;
        idx_q   <= 3'd0;
        stop_q  <= 2'd0;
        line_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          IDLE: ;
          START: begin
            state_q <= DATA;
            idx_q   <= 3'd0;
            line_q  <= shift_q[0];
          end
          DATA: begin
            if (idx_q == 3'd7) begin
              state_q <= PARITY;
              line_q  <= par_q;
            end else begin
              idx_q  <= idx_q + 3'd1;
              line_q <= shift_q[idx_q + 3'd1];
            end
          end
          PARITY: begin
            state_q <= STOP;
            stop_q  <= 2'd0;
            line_q  <= 1'b1;
          end
          STOP: begin
            if (stop_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              line_q  <= 1'b1;
              idx_q   <= 3'd0;
              stop_q  <= 2'd0;
            end else begin
              stop_q <= stop_q + 2'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign host.Ready    = ~full_q;
  assign Serial_output = line_q;
  assign Busy          = busy_q;
  assign Tx_Done       = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: two instances (even/1 stop, odd/2 stop) against a frame-queue reference model.
module tb_uart_frame_tx;
  logic clk = 1'b0;
  logic clr, baud;
  logic line0, busy0, done0, line1, busy1, done1;

  uart_frame_tx_if bus0 ();
  uart_frame_tx_if bus1 ();

  uart_frame_tx u0 (
    .CLK(clk), .CLR(clr), .CLK_Baud(baud), .host(bus0),
    .Serial_output(line0), .Busy(busy0), .Tx_Done(done0)
  );
  uart_frame_tx #(.PARITY_ODD(1'b1), .STOP_BITS(2)) u1 (
    .CLK(clk), .CLR(clr), .CLK_Baud(baud), .host(bus1),
    .Serial_output(line1), .Busy(busy1), .Tx_Done(done1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: each instance keeps a queue of line bits still to be sent.
  int         podd[2] = '{0, 1};
  int         nstp[2] = '{1, 2};
  int         q[2][$];
  bit         endf[2], pend[2];
  logic [7:0] pbyte[2];
  bit         eline[2], ebusy[2], edone[2];
  bit         bprev, tick_now;
  int         cyc, tickcnt;
  bit         cap;
  int         ncap;
  logic [10:0] seq;
  int         dq[$];

  task automatic model(input bit dv, input logic [7:0] d, input bit rst);
    if (rst) begin
      bprev    = 1'b0;
      tick_now = 1'b0;
      for (int n = 0; n < 2; n++) begin
        q[n].delete();
        endf[n] = 0; pend[n] = 0;
        eline[n] = 1; ebusy[n] = 0; edone[n] = 0;
      end
    end else begin
      tick_now = !bprev && baud;
      bprev    = baud;
      if (tick_now) tickcnt++;
      for (int n = 0; n < 2; n++) begin
        bit was;
        was = pend[n];
        edone[n] = 0;
        if (tick_now) begin
          if (endf[n]) begin
            edone[n] = 1;
            endf[n]  = 0;
          end
          if (q[n].size() == 0 && pend[n]) begin
            q[n].push_back(0);
            for (int i = 0; i < 8; i++) q[n].push_back(int'(pbyte[n][i]));
            q[n].push_back(int'(^pbyte[n]) ^ podd[n]);
            for (int s = 0; s < nstp[n]; s++) q[n].push_back(1);
            pend[n] = 0;
          end
          if (q[n].size() != 0) begin
            eline[n] = bit'(q[n].pop_front());
            ebusy[n] = 1;
            endf[n]  = (q[n].size() == 0);
          end else begin
            eline[n] = 1;
            ebusy[n] = 0;
          end
        end
        if (dv && !was) begin
          pend[n]  = 1;
          pbyte[n] = d;
        end
      end
    end
  endtask

  task automatic step(input bit dv, input logic [7:0] d, input bit rst);
    baud = ((cyc % 8) >= 4);
    cyc++;
    clr = rst;
    bus0.Data_Valid = dv; bus0.Data = d;
    bus1.Data_Valid = dv; bus1.Data = d;
    model(dv, d, rst);
    @(posedge clk);
    #1;
    chk("line0",  32'(line0),      32'(eline[0]));
    chk("busy0",  32'(busy0),      32'(ebusy[0]));
    chk("done0",  32'(done0),      32'(edone[0]));
    chk("ready0", 32'(bus0.Ready), 32'(!pend[0]));
    chk("line1",  32'(line1),      32'(eline[1]));
    chk("busy1",  32'(busy1),      32'(ebusy[1]));
    chk("done1",  32'(done1),      32'(edone[1]));
    chk("ready1", 32'(bus1.Ready), 32'(!pend[1]));
    if (cap && tick_now && ncap < 11) begin
      seq = {seq[9:0], line0};
      ncap++;
    end
    if (done0) dq.push_back(tickcnt);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'b0);
  endtask

  // Step until the next cycle is the start of a baud-low phase, so a load never lands on a tick.
  task automatic align();
    while (cyc % 8 != 0) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic wait_ticks(input int n);
    int start, guard;
    start = tickcnt;
    guard = 0;
    while (tickcnt - start < n && guard < n * 8 + 32) begin
      step(1'b0, 8'($urandom), 1'b0);
      guard++;
    end
    chk("tick_wait", 32'(tickcnt - start), 32'(n));
  endtask

  logic [7:0] blist[6] = '{8'h55, 8'h07, 8'h00, 8'hFF, 8'hC3, 8'hA5};

  initial begin
    cyc = 0; tickcnt = 0; cap = 0; ncap = 0; seq = '0;
    repeat (3) step(1'b0, 8'h00, 1'b1);
    idle(5);

    foreach (blist[k]) begin
      align();
      cap = 1; ncap = 0; seq = '0;
      step(1'b1, blist[k], 1'b0);
      idle(130);
      cap = 0;
      chk("frame_bits", 32'(ncap), 32'd11);
      if (blist[k] == 8'h55) chk("seq55", 32'(seq), 32'(11'b01010101001));
      if (blist[k] == 8'h07) chk("par07", 32'(seq[1]), 32'd1);
    end

    dq.delete();
    align();
    step(1'b1, 8'h12, 1'b0);
    idle(20);
    step(1'b1, 8'h34, 1'b0);
    repeat (10) step(1'b1, 8'($urandom), 1'b0);
    idle(250);
    chk("b2b_done_cnt", 32'(dq.size()), 32'd2);
    if (dq.size() == 2) chk("b2b_gap", 32'(dq[1] - dq[0]), 32'd11);

    align();
    step(1'b1, 8'hA5, 1'b0);
    wait_ticks(6);
    idle(2);
    dq.delete();
    step(1'b1, 8'h3C, 1'b1);
    idle(3);
    align();
    step(1'b1, 8'h81, 1'b0);
    idle(130);
    chk("clr_done_cnt", 32'(dq.size()), 32'd1);

    repeat (4000)
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 599) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
